ahb_mtx_in_stg: RTL
===================

AHB_MTX_IN_STG -- requirements
Module: ahb_mtx_in_stg

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low.
REQ-002 SHALL: HCLK  in  1  AHB system clock, all state on rising edge.
REQ-003 SHALL: HRESETn  in  1  async active-low reset.
REQ-004 SHALL: HSELS  in  1  master-port slave select.
REQ-005 SHALL: HADDRS/HAUSERS  in  32/32  master address, address user bits.
REQ-006 SHALL: HTRANSS, HWRITES, HSIZES, HBURSTS  in  2/1/3/3  master transfer control.
REQ-007 SHALL: HPROTS, HMASTERS, HMASTLOCKS  in  4/4/1  master protection, ID, lock.
REQ-008 SHALL: HWDATAS/HWUSERS  in  32/32  master write data, data user bits.
REQ-009 SHALL: HREADYS  in  1  master-side HREADY (address phase valid when high).
REQ-010 SHALL: sel_ip, addr_ip, auser_ip, trans_ip, write_ip, size_ip, burst_ip, prot_ip, master_ip, mastlock_ip  out  1/32/32/2/1/3/3/4/4/1  transfer presented to output stages.
REQ-011 SHALL: wdata_ip/wuser_ip  out  32/32  pass-through of HWDATAS/HWUSERS.
REQ-012 SHALL: held_tran_ip  out  1  valid transfer request (pending or live NONSEQ/SEQ).
REQ-013 SHALL: active_ip  in  1  the output stage addressed by this port has granted it.
REQ-014 SHALL: readymux_ip  in  1  HREADYMUX of the granted output stage.
REQ-015 SHALL: readyout_ip/resp_ip  in  1/1  data-phase HREADYOUT/HRESP from the slave path.
REQ-016 SHALL: HREADYOUTS/HRESPS  out  1/1  ready and response returned to master.

Function
REQ-017 SHALL: live_req = HSELS & HTRANSS[1] & HREADYS; accept = active_ip & readymux_ip.
REQ-018 SHALL: state pend_reg (0 IDLE_PASS, 1 HOLD); IDLE_PASS->HOLD on live_req & ~accept; HOLD->IDLE_PASS on accept; otherwise hold state.
REQ-019 SHALL: on IDLE_PASS->HOLD, capture all address/control inputs of REQ-005..007 plus HSELS into holding registers in the same edge.
REQ-020 SHALL: in HOLD, drive *_ip from holding registers; in IDLE_PASS drive them directly from master inputs (zero latency).
REQ-021 SHALL: held transfer presented with trans_ip=2'b10 (NONSEQ) regardless of captured HTRANSS.
REQ-022 SHALL: held fixed-length bursts (HBURSTS 3'b010..3'b111) presented as burst_ip=3'b001 (INCR); SINGLE/INCR unchanged.
REQ-023 SHALL: held_tran_ip = pend_reg | live_req.
REQ-024 SHALL: dphase_reg set at edge where (pend_reg | live_req) & accept; cleared at edge where ~((pend_reg | live_req) & accept) & (~dphase_reg | readyout_ip).
REQ-025 SHALL: HREADYOUTS = 0 when pend_reg=1; else readyout_ip when dphase_reg=1; else 1.
REQ-026 SHALL: HRESPS = resp_ip when dphase_reg=1 & pend_reg=0; else 0 (OKAY).
REQ-027 SHALL: IDLE/BUSY or HSELS=0 with pend_reg=0: no capture, held_tran_ip=0, zero-wait OKAY once dphase_reg clears.
REQ-028 SHALL: simultaneous live_req and accept in IDLE_PASS: no capture, pend_reg stays 0.
REQ-029 SHALL: pending transfer never dropped or duplicated; HOLD exits only via accept.
REQ-030 SHALL: mastlock_ip held from holding register in HOLD so arbiter lock tracking is preserved.

Reset
REQ-031 SHALL: while HRESETn=0: pend_reg=0, dphase_reg=0, holding registers=0, HREADYOUTS=1, HRESPS=0, held_tran_ip=0 (master idle).
REQ-032 SHALL: reset asserted mid-HOLD discards the pending transfer immediately (asynchronously), no acceptance after release.

Verification
REQ-033 SHALL: NONSEQ addr 0x2000_0010 with active_ip=1, readymux_ip=1 -> addr_ip=0x2000_0010 same cycle, no HOLD, next cycle HREADYOUTS=readyout_ip.
REQ-034 SHALL: SEQ INCR4 addr 0x0000_0104 with active_ip=0 for 3 cycles -> HOLD, trans_ip=2'b10, burst_ip=3'b001, addr_ip=0x0000_0104 stable, HREADYOUTS=0; accept -> HOLD exits next edge.
REQ-035 SHALL: data phase with readyout_ip=0 two cycles, resp_ip=1 -> HREADYOUTS 0,0,1 and HRESPS=1 mirrored.
REQ-036 SHALL: HTRANSS=IDLE with HSELS=1 -> held_tran_ip=0, HREADYOUTS=1, HRESPS=0.
REQ-037 SHALL: HRESETn low during HOLD -> pend_reg=0, held_tran_ip=0, HREADYOUTS=1 before next HCLK edge.
REQ-038 SHALL: locked transfer (HMASTLOCKS=1) held 2 cycles -> mastlock_ip=1 throughout HOLD, cleared only after master deasserts lock.

Source files
------------

// File: rtl/ahb_mtx_in_stg.sv
// AHB matrix input stage: presents a master's transfer to the output stages
// with zero latency when granted, and parks it in a holding register (stalling
// the master) when the addressed output stage has not yet accepted it.
module ahb_mtx_in_stg (
  input  logic        HCLK,
  input  logic        HRESETn,
  // master port
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [31:0] HAUSERS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [3:0]  HMASTERS,
  input  logic        HMASTLOCKS,
  input  logic [31:0] HWDATAS,
  input  logic [31:0] HWUSERS,
  input  logic        HREADYS,
  // towards output stages
  output logic        sel_ip,
  output logic [31:0] addr_ip,
  output logic [31:0] auser_ip,
  output logic [1:0]  trans_ip,
  output logic        write_ip,
  output logic [2:0]  size_ip,
  output logic [2:0]  burst_ip,
  output logic [3:0]  prot_ip,
  output logic [3:0]  master_ip,
  output logic        mastlock_ip,
  output logic [31:0] wdata_ip,
  output logic [31:0] wuser_ip,
  output logic        held_tran_ip,
  // from output stage / slave path
  input  logic        active_ip,
  input  logic        readymux_ip,
  input  logic        readyout_ip,
  input  logic        resp_ip,
  // back to master
  output logic        HREADYOUTS,
  output logic        HRESPS
);

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] auser;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        lock;
  } req_t;

  typedef enum logic {IDLE_PASS = 1'b0, HOLD = 1'b1} state_t;

  state_t state_q, state_d;
  req_t   live_s, hold_q, hold_d, pres;
  logic   dphase_q, dphase_d;
  logic   live_req, accept, pend, req_any;

  assign pend     = (state_q == HOLD);
  assign live_req = HSELS & HTRANSS[1] & HREADYS;
  assign accept   = active_ip & readymux_ip;
  assign req_any  = pend | live_req;

  // Bundle the live master address/control into one request word
  always_comb begin
    live_s        = '0;
    live_s.sel    = HSELS;
    live_s.addr   = HADDRS;
    live_s.auser  = HAUSERS;
    live_s.trans  = HTRANSS;
    live_s.write  = HWRITES;
    live_s.size   = HSIZES;
    live_s.burst  = HBURSTS;
    live_s.prot   = HPROTS;
    live_s.master = HMASTERS;
    live_s.lock   = HMASTLOCKS;
  end

  // Next-state: park an unaccepted live request, release on accept
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE_PASS: begin
        if (live_req && !accept) begin
          state_d = HOLD;
          hold_d  = live_s;
        end
      end
      HOLD: begin
        if (accept) state_d = IDLE_PASS;
      end
      default: state_d = IDLE_PASS;
    endcase
  end

  // State register; reset discards any parked transfer immediately
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= IDLE_PASS;
    else          state_q <= state_d;
  end

  // Holding register for the parked request
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hold_q <= '0;
    else          hold_q <= hold_d;
  end

  // Select the presented request. A parked transfer is re-issued as a fresh
  // NONSEQ, so a fixed-length burst can no longer promise its beat count and
  // is downgraded to INCR.
  always_comb begin
    pres = live_s;
    if (pend) begin
      pres       = hold_q;
      pres.trans = 2'b10;
      if (hold_q.burst[2:1] != 2'b00) pres.burst = 3'b001;
    end
  end

  assign sel_ip       = pres.sel;
  assign addr_ip      = pres.addr;
  assign auser_ip     = pres.auser;
  assign trans_ip     = pres.trans;
  assign write_ip     = pres.write;
  assign size_ip      = pres.size;
  assign burst_ip     = pres.burst;
  assign prot_ip      = pres.prot;
  assign master_ip    = pres.master;
  assign mastlock_ip  = pres.lock;
  assign wdata_ip     = HWDATAS;
  assign wuser_ip     = HWUSERS;
  assign held_tran_ip = req_any;

  // Data-phase tracking: set when a request is accepted, cleared once the
  // slave completes and no new request takes its place
  always_comb begin
    dphase_d = dphase_q;
    if (req_any && accept)              dphase_d = 1'b1;
    else if (!dphase_q || readyout_ip)  dphase_d = 1'b0;
  end

  // Data-phase flag register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dphase_q <= 1'b0;
    else          dphase_q <= dphase_d;
  end

  // Master-side response: stall while parked, mirror the slave in data phase
  assign HREADYOUTS = pend ? 1'b0 : (dphase_q ? readyout_ip : 1'b1);
  assign HRESPS     = dphase_q & ~pend & resp_ip;

endmodule
